multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Multicycle MIPS control unit: a Moore FSM that sequences every instruction over 3–5 clock cycles and shares one ALU and one unified memory port. It drives the datapath selects and enables, decodes `funct` for R-type ALU operations, and flags unrecognised encodings. Opcode values are parameters, so one RTL serves custom encodings.

## Interface

Parameters:
- `OP_RTYPE`, 6'b000000, R-type opcode
- `OP_LW`, 6'b100011, load word
- `OP_SW`, 6'b101011, store word
- `OP_BEQ`, 6'b000100, branch if equal
- `OP_ADDI`, 6'b001000, add immediate
- `OP_J`, 6'b000010, jump
- `OP_BNE`, 6'b000101, branch if not equal (used only when the macro below is defined)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `opcode` in 6: IR[31:26], stable from the DECODE cycle on
- `funct` in 6: IR[5:0]
- `zero` in 1: ALU zero flag, same cycle
- `IorD` out 1: memory address select, 0 = PC, 1 = ALUOut
- `MemWrite` out 1: memory write enable
- `IRWrite` out 1: instruction register load
- `RegWrite` out 1: register file write
- `RegDst` out 1: 1 = rd, 0 = rt
- `MemtoReg` out 1: 1 = Data register, 0 = ALUOut
- `ALUSrcA` out 1: 0 = PC, 1 = register A
- `ALUSrcB` out 2: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
- `PCSrc` out 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- `PCEn` out 1: PC load = PCWrite | (Branch & branch condition)
- `ALUControl` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt
- `illegal_op` out 1: unrecognised opcode or funct, DECODE cycle only
- `state` out 4: current state encoding, for debug

## Operation

State encodings:
- FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5
- EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEX = 9, ADDIWB = 10, JUMP = 11

Outputs are decoded from `state` only. `PCEn` and `ALUControl` also depend on `zero` and `funct`. Any signal not listed for a state is 0.

Per-state outputs:
- FETCH: IRWrite, PCWrite, ALUSrcB = 01, ALUOp = add. Next state DECODE.
- DECODE: ALUSrcB = 11, ALUOp = add (computes branch target). Next state by opcode:
  - LW or SW → MEMADR
  - RTYPE → EXECUTE
  - BEQ or BNE → BRANCH
  - ADDI → ADDIEX
  - J → JUMP
  - anything else → FETCH with `illegal_op` = 1. An RTYPE with an unknown funct is also illegal.
- MEMADR: ALUSrcA, ALUSrcB = 10, add. Next state MEMRD for LW, MEMWR for SW.
- MEMRD: IorD. Next state MEMWB.
- MEMWB: RegWrite, MemtoReg. Next state FETCH.
- MEMWR: IorD, MemWrite. Next state FETCH.
- EXECUTE: ALUSrcA, ALUOp = funct. Next state ALUWB.
- ALUWB: RegDst, RegWrite. Next state FETCH.
- BRANCH: ALUSrcA, ALUOp = sub, PCSrc = 01, Branch.
  - BEQ: PCEn = zero.
  - BNE: PCEn = !zero.
  - Next state FETCH.
- ADDIEX: ALUSrcA, ALUSrcB = 10, add. Next state ADDIWB.
- ADDIWB: RegWrite. Next state FETCH.
- JUMP: PCSrc = 10, PCWrite. Next state FETCH.

ALU decode:
- ALUOp add → 010; ALUOp sub → 110.
- ALUOp funct:
  - 100000 → 010
  - 100010 → 110
  - 100100 → 000
  - 100101 → 001
  - 101010 → 111
  - any other funct → 010
- Undefined state codes 12–15 go to FETCH with all enables 0.

## Timing

- State register updates on the rising edge of `clk`; all outputs are combinational from that register.
- During a cycle with `reset` = 1:
  - `state` = FETCH.
  - MemWrite, IRWrite, RegWrite, PCEn forced to 0.
  - Selects take their FETCH values: IorD = 0, ALUSrcA = 0, ALUSrcB = 01, PCSrc = 00, ALUControl = 010.
  - `illegal_op` = 0.
- First fetch happens in the first cycle after `reset` deasserts.
- Cycles per instruction:
  - LW 5
  - SW 4
  - R-type 4
  - ADDI 4
  - BEQ/BNE 3
  - J 3
  - illegal 2
- Reset asserted mid-instruction aborts it: in that cycle no write occurs and the next state is FETCH.

## Configuration

- `MC_CTRL_BNE_EN` defined: `OP_BNE` decodes to BRANCH with the inverted condition, PCEn = !zero.
- `MC_CTRL_BNE_EN` undefined: `OP_BNE` is illegal, so DECODE → FETCH with `illegal_op` = 1.

## Test plan

- Reset held 3 cycles with random opcode → state = 0, all enables 0. After release: state sequence 0,1 with IRWrite = 1 and PCEn = 1 in the FETCH cycle.
- LW (opcode 100011) → states 0,1,2,3,4. IorD = 1 in state 3; RegWrite = 1 and MemtoReg = 1 in state 4. Then SW → 0,1,2,5 with MemWrite = 1 only in state 5.
- R-type with funct 100010, then 101010 → ALUControl 110, then 111 in EXECUTE. RegDst = 1 and RegWrite = 1 in ALUWB. Funct 000111 → illegal_op = 1 in DECODE, next state 0.
- BEQ with zero = 1 → PCEn = 1, PCSrc = 01 in state 8. With zero = 0 → PCEn = 0. J → state 11 with PCSrc = 10, PCEn = 1.
- Opcode 000101:
  - with the macro: zero = 0 → PCEn = 1 in state 8.
  - without the macro: illegal_op = 1, 2-cycle return to FETCH.
- Reset asserted in state 5 (SW) → MemWrite = 0 in that cycle, state 0 on the next cycle.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control unit: Moore FSM driving datapath selects/enables over 3-5 cycles.
// Define MC_CTRL_BNE_EN to decode OP_BNE as a branch taken on !zero; otherwise OP_BNE is illegal.
module multicycle_controller #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_BNE   = 6'b000101
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [2:0] ALUControl,
    output logic       illegal_op,
    output logic [3:0] state
);

`ifdef MC_CTRL_BNE_EN
    localparam logic BNE_EN = 1'b1;
`else
    localparam logic BNE_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    state_t cur_state;
    state_t next_state;
    state_t out_state;
    aluop_t alu_op;
    logic   pc_write;
    logic   branch;
    logic   branch_taken;
    logic   funct_known;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        funct_known = 1'b0;
        case (funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_known = 1'b1;
            default: funct_known = 1'b0;
        endcase
    end

    // While reset is high the outputs look like FETCH with every write enable suppressed.
    always_comb begin
        out_state  = reset ? FETCH : cur_state;
        next_state = FETCH;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        alu_op     = ALUOP_ADD;
        pc_write   = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;
        case (out_state)
            FETCH: begin
                IRWrite    = 1'b1;
                pc_write   = 1'b1;
                ALUSrcB    = 2'b01;
                next_state = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    next_state = MEMADR;
                end else if (opcode == OP_RTYPE && funct_known) begin
                    next_state = EXECUTE;
                end else if (opcode == OP_BEQ || (BNE_EN && opcode == OP_BNE)) begin
                    next_state = BRANCH;
                end else if (opcode == OP_ADDI) begin
                    next_state = ADDIEX;
                end else if (opcode == OP_J) begin
                    next_state = JUMP;
                end else begin
                    illegal_op = 1'b1;
                end
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD       = 1'b1;
                next_state = MEMWB;
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA    = 1'b1;
                alu_op     = ALUOP_FUNCT;
                next_state = ALUWB;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                RegWrite = 1'b1;
            end
            JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
                next_state = FETCH;
            end
        endcase
        if (reset) begin
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            pc_write   = 1'b0;
            branch     = 1'b0;
            illegal_op = 1'b0;
            next_state = FETCH;
        end
    end

    // The opcode is held stable through BRANCH, so it still tells BEQ from BNE there.
    always_comb begin
        branch_taken = (BNE_EN && opcode == OP_BNE) ? ~zero : zero;
        PCEn         = pc_write | (branch & branch_taken);
    end

    always_comb begin
        ALUControl = 3'b010;
        case (alu_op)
            ALUOP_ADD: ALUControl = 3'b010;
            ALUOP_SUB: ALUControl = 3'b110;
            ALUOP_FUNCT: begin
                case (funct)
                    6'b100000: ALUControl = 3'b010;
                    6'b100010: ALUControl = 3'b110;
                    6'b100100: ALUControl = 3'b000;
                    6'b100101: ALUControl = 3'b001;
                    6'b101010: ALUControl = 3'b111;
                    default:   ALUControl = 3'b010;
                endcase
            end
            default: ALUControl = 3'b010;
        endcase
    end

    assign state = out_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction cycle model plus directed pins.
module tb_multicycle_controller;

    localparam int K_LW   = 0;
    localparam int K_SW   = 1;
    localparam int K_R    = 2;
    localparam int K_ADDI = 3;
    localparam int K_BR   = 4;
    localparam int K_J    = 5;
    localparam int K_ILL  = 6;

    typedef struct packed {
        logic [3:0] st;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [2:0] aluctl;
        logic       ill;
    } vec_t;

    typedef struct packed {
        vec_t v;
        int   instr;
        int   step;
    } entry_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, PCEn, illegal_op;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    int     checkCount = 0;
    int     failCount  = 0;
    int     instrNum   = 0;
    entry_t expQueue[$];
    entry_t cmpEntry;
    vec_t   actual;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .PCEn(PCEn), .ALUControl(ALUControl), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    assign actual = {state, IorD, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
                     ALUSrcB, PCSrc, PCEn, ALUControl, illegal_op};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] functCtl(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b100011) return K_LW;
        if (op == 6'b101011) return K_SW;
        if (op == 6'b000100) return K_BR;
        if (op == 6'b001000) return K_ADDI;
        if (op == 6'b000010) return K_J;
`ifdef MC_CTRL_BNE_EN
        if (op == 6'b000101) return K_BR;
`endif
        if (op == 6'b000000 && (fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
                                fn == 6'b100101 || fn == 6'b101010)) return K_R;
        return K_ILL;
    endfunction

    function automatic int lenOf(input int kind);
        case (kind)
            K_LW:               return 5;
            K_SW, K_R, K_ADDI:  return 4;
            K_BR, K_J:          return 3;
            default:            return 2;
        endcase
    endfunction

    function automatic vec_t resetVec();
        vec_t v = '0;
        v.alusrcb = 2'b01;
        v.aluctl  = 3'b010;
        return v;
    endfunction

    // Expected outputs for cycle 'step' of an instruction of class 'kind'.
    function automatic vec_t modelCycle(input int kind, input int step, input logic [5:0] fn,
                                        input logic isBne, input logic z);
        vec_t v = '0;
        v.aluctl = 3'b010;
        if (step == 0) begin
            v.irwrite = 1'b1; v.pcen = 1'b1; v.alusrcb = 2'b01;
        end else if (step == 1) begin
            v.st = 4'd1; v.alusrcb = 2'b11; v.ill = (kind == K_ILL);
        end else if ((kind == K_LW || kind == K_SW) && step == 2) begin
            v.st = 4'd2; v.alusrca = 1'b1; v.alusrcb = 2'b10;
        end else if (kind == K_LW && step == 3) begin
            v.st = 4'd3; v.iord = 1'b1;
        end else if (kind == K_LW && step == 4) begin
            v.st = 4'd4; v.regwrite = 1'b1; v.memtoreg = 1'b1;
        end else if (kind == K_SW && step == 3) begin
            v.st = 4'd5; v.iord = 1'b1; v.memwrite = 1'b1;
        end else if (kind == K_R && step == 2) begin
            v.st = 4'd6; v.alusrca = 1'b1; v.aluctl = functCtl(fn);
        end else if (kind == K_R && step == 3) begin
            v.st = 4'd7; v.regdst = 1'b1; v.regwrite = 1'b1;
        end else if (kind == K_ADDI && step == 2) begin
            v.st = 4'd9; v.alusrca = 1'b1; v.alusrcb = 2'b10;
        end else if (kind == K_ADDI && step == 3) begin
            v.st = 4'd10; v.regwrite = 1'b1;
        end else if (kind == K_BR) begin
            v.st = 4'd8; v.alusrca = 1'b1; v.aluctl = 3'b110; v.pcsrc = 2'b01;
            v.pcen = isBne ? ~z : z;
        end else if (kind == K_J) begin
            v.st = 4'd11; v.pcsrc = 2'b10; v.pcen = 1'b1;
        end
        return v;
    endfunction

    task automatic checkPin(input int pinId, input int step);
        @(negedge clk);
        case (pinId)
            2: begin
                if (step == 0) checkOutput("lw_fetch_irwrite_pcen", 32'({IRWrite, PCEn}), 32'd3);
                if (step == 1) checkOutput("lw_decode_state", 32'(state), 32'd1);
                if (step == 3) checkOutput("lw_memrd_iord", 32'({state, IorD}), 32'h7);
                if (step == 4) checkOutput("lw_memwb_regwrite_memtoreg", 32'({RegWrite, MemtoReg}), 32'd3);
            end
            3: begin
                if (step == 2) checkOutput("sw_memadr_memwrite", 32'(MemWrite), 32'd0);
                if (step == 3) checkOutput("sw_memwr_memwrite", 32'({state, MemWrite}), 32'hB);
            end
            4: begin
                if (step == 2) checkOutput("r_sub_aluctl", 32'(ALUControl), 32'h6);
                if (step == 3) checkOutput("r_aluwb_regdst_regwrite", 32'({RegDst, RegWrite}), 32'd3);
            end
            5: if (step == 2) checkOutput("r_slt_aluctl", 32'(ALUControl), 32'h7);
            6: if (step == 1) checkOutput("r_badfunct_illegal", 32'(illegal_op), 32'd1);
            7: if (step == 2) checkOutput("beq_taken_pcen_pcsrc", 32'({PCEn, PCSrc}), 32'h5);
            8: if (step == 2) checkOutput("beq_nottaken_pcen", 32'(PCEn), 32'd0);
            9: if (step == 2) checkOutput("j_state_pcsrc_pcen", 32'({state, PCSrc, PCEn}), 32'h5D);
            10: begin
`ifdef MC_CTRL_BNE_EN
                if (step == 2) checkOutput("bne_taken_pcen", 32'({state, PCEn}), 32'h11);
`else
                if (step == 1) checkOutput("bne_disabled_illegal", 32'(illegal_op), 32'd1);
`endif
            end
            11: if (step == 3) checkOutput("sw_abort_memwrite_state", 32'({state, MemWrite}), 32'h0);
            default: ;
        endcase
    endtask

    // One instruction; abortStep >= 0 raises reset on that cycle and ends the instruction there.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic zBr,
                                 input int abortStep, input int pinId);
        int     kind  = classify(op, fn);
        int     len   = lenOf(kind);
        logic   isBne = (op == 6'b000101);
        entry_t e;
        instrNum++;
        for (int s = 0; s < len; s++) begin
            @(posedge clk);
            #1;
            e.instr = instrNum;
            e.step  = s;
            if (s == abortStep) begin
                reset  = 1'b1;
                opcode = op;
                funct  = fn;
                zero   = 1'($urandom);
                e.v    = resetVec();
                expQueue.push_back(e);
                if (pinId != 0) checkPin(pinId, s);
                break;
            end
            reset  = 1'b0;
            opcode = (s == 0) ? 6'($urandom) : op;
            funct  = (s == 0) ? 6'($urandom) : fn;
            zero   = (kind == K_BR && s == 2) ? zBr : 1'($urandom);
            e.v    = modelCycle(kind, s, fn, isBne, zero);
            expQueue.push_back(e);
            if (pinId != 0) checkPin(pinId, s);
        end
    endtask

    always @(negedge clk) begin
        if (expQueue.size() > 0) begin
            cmpEntry = expQueue.pop_front();
            checkOutput($sformatf("instr%0d_step%0d", cmpEntry.instr, cmpEntry.step),
                        32'(actual), 32'(cmpEntry.v));
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        entry_t e;
        logic [5:0] op;
        logic [5:0] fn;
        int kind;
        int abortStep;
        reset  = 1'b1;
        opcode = 6'($urandom);
        funct  = 6'($urandom);
        zero   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            reset  = 1'b1;
            opcode = 6'($urandom);
            zero   = 1'($urandom);
            e.v = resetVec(); e.instr = 0; e.step = i;
            expQueue.push_back(e);
        end
        @(negedge clk);
        checkOutput("reset_state_enables", 32'({state, MemWrite, IRWrite, RegWrite, PCEn}), 32'h0);

        $display("[TB] directed sequence");
        applyStimulus(6'b100011, 6'($urandom), 1'b0, -1, 2);
        applyStimulus(6'b101011, 6'($urandom), 1'b0, -1, 3);
        applyStimulus(6'b000000, 6'b100010, 1'b0, -1, 4);
        applyStimulus(6'b000000, 6'b101010, 1'b0, -1, 5);
        applyStimulus(6'b000000, 6'b000111, 1'b0, -1, 6);
        applyStimulus(6'b000100, 6'($urandom), 1'b1, -1, 7);
        applyStimulus(6'b000100, 6'($urandom), 1'b0, -1, 8);
        applyStimulus(6'b000010, 6'($urandom), 1'b0, -1, 9);
        applyStimulus(6'b000101, 6'($urandom), 1'b0, -1, 10);
        applyStimulus(6'b101011, 6'($urandom), 1'b0, 3, 11);
        applyStimulus(6'b001000, 6'($urandom), 1'b0, -1, 0);

        $display("[TB] random sequence");
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(7, 0))
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b001000;
                5: op = 6'b000010;
                6: op = 6'b000101;
                default: op = 6'($urandom);
            endcase
            case ($urandom_range(6, 0))
                0: fn = 6'b100000;
                1: fn = 6'b100010;
                2: fn = 6'b100100;
                3: fn = 6'b100101;
                4: fn = 6'b101010;
                default: fn = 6'($urandom);
            endcase
            kind = classify(op, fn);
            abortStep = ($urandom_range(11, 0) == 0) ? int'($urandom_range(lenOf(kind) - 1, 0)) : -1;
            applyStimulus(op, fn, 1'($urandom), abortStep, 0);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
